cpu_bus_arb: RTL and testbench

Round-robin arbiter and cycle sequencer for the shared CPU register bus. It accepts single-word read/write requests from `NUM_REQ` internal masters, such as the host-management bridge and the config loader. It drives one fixed-length bus access at a time onto `cpu_addr`/`cpu_cs`/`cpu_wr`/`cpu_rd`/`cpu_data_in`, captures `cpu_data_out` on reads, and returns a response to the owning requester. It sits between the requesters and the register-bank slaves, which have no ready/ack signal, so the access length is fixed.

---
 rtl/cpu_bus_pkg.sv | 13 +
 rtl/cpu_bus_arb_if.sv | 35 +++
 rtl/rr_arbiter.sv | 37 +++
 rtl/cpu_bus_arb.sv | 102 ++++++++++
 tb/tb_cpu_bus_arb.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared widths and FSM state type for the CPU register bus arbiter.
package cpu_bus_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        TURN
    } cpu_arb_state_e;

endpackage

// File: rtl/cpu_bus_arb_if.sv
// Requester handshake plus CPU register bus signals of the arbiter.
// The arbiter connects through the slave modport. The requester/bus-model
// side uses the master modport.
interface cpu_bus_arb_if #(
    parameter int NUM_REQ = 2
);
    import cpu_bus_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_wr;
    logic [NUM_REQ*CPU_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*CPU_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [CPU_DATA_W-1:0]         rsp_rdata;
    logic [CPU_ADDR_W-1:0]         cpu_addr;
    logic                          cpu_cs;
    logic                          cpu_wr;
    logic                          cpu_rd;
    logic [CPU_DATA_W-1:0]         cpu_data_in;
    logic [CPU_DATA_W-1:0]         cpu_data_out;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, cpu_data_out,
        input  req_ready, rsp_valid, rsp_rdata,
        input  cpu_addr, cpu_cs, cpu_wr, cpu_rd, cpu_data_in
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, cpu_data_out,
        output req_ready, rsp_valid, rsp_rdata,
        output cpu_addr, cpu_cs, cpu_wr, cpu_rd, cpu_data_in
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// The search starts at ptr and wraps around. It returns a one-hot grant,
// the binary index of the winner, and a flag that is set when any
// request was seen.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW:0] pos;

    // Walk the requesters from ptr upward; the first one found wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, ptr} + (IW+1)'(i);
            if (pos >= (IW+1)'(N)) begin
                pos = pos - (IW+1)'(N);
            end
            if (!found && req[pos[IW-1:0]]) begin
                found              = 1'b1;
                gnt[pos[IW-1:0]]   = 1'b1;
                idx                = pos[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arb.sv
// Round-robin arbiter and fixed-length cycle sequencer for the shared
// CPU register bus. The slaves have no ack, so every access holds cs
// for exactly ACC_CYC cycles. A TURN cycle follows each access and
// returns the response.
module cpu_bus_arb
    import cpu_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ACC_CYC = 2
) (
    input logic           cpu_clk,
    input logic           rst,
    cpu_bus_arb_if.slave  bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACC_CYC + 1);

    cpu_arb_state_e        state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         owner;
    logic                  acc_wr;
    logic [CW-1:0]         cnt;
    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  gnt_found;
    logic [CPU_ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [CPU_DATA_W-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = bus.req_addr[i*CPU_ADDR_W +: CPU_ADDR_W];
        assign wdata_arr[i] = bus.req_wdata[i*CPU_DATA_W +: CPU_DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    assign bus.req_ready = (state == IDLE && !rst) ? gnt : '0;

    // Sequencer: accept in IDLE, hold the bus for ACC_CYC cycles, then respond in TURN.
    always_ff @(posedge cpu_clk) begin
        if (rst) begin
            state           <= IDLE;
            ptr             <= '0;
            owner           <= '0;
            acc_wr          <= 1'b0;
            cnt             <= '0;
            bus.cpu_addr    <= '0;
            bus.cpu_cs      <= 1'b0;
            bus.cpu_wr      <= 1'b0;
            bus.cpu_rd      <= 1'b0;
            bus.cpu_data_in <= '0;
            bus.rsp_valid   <= '0;
            bus.rsp_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        owner           <= gnt_idx;
                        acc_wr          <= bus.req_wr[gnt_idx];
                        cnt             <= CW'(ACC_CYC - 1);
                        ptr             <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        bus.cpu_addr    <= addr_arr[gnt_idx];
                        bus.cpu_cs      <= 1'b1;
                        bus.cpu_wr      <= bus.req_wr[gnt_idx];
                        bus.cpu_rd      <= !bus.req_wr[gnt_idx];
                        bus.cpu_data_in <= bus.req_wr[gnt_idx] ? wdata_arr[gnt_idx] : '0;
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        bus.cpu_addr     <= '0;
                        bus.cpu_cs       <= 1'b0;
                        bus.cpu_wr       <= 1'b0;
                        bus.cpu_rd       <= 1'b0;
                        bus.cpu_data_in  <= '0;
                        bus.rsp_valid    <= '0;
                        bus.rsp_valid[owner] <= 1'b1;
                        bus.rsp_rdata    <= acc_wr ? '0 : bus.cpu_data_out;
                        state            <= TURN;
                    end
                end
                TURN: begin
                    bus.rsp_valid <= '0;
                    bus.rsp_rdata <= '0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Testbench for cpu_bus_arb. It runs two builds, ACC_CYC=2 and ACC_CYC=1,
// on shared stimulus. Each cycle is compared against a transaction-level
// timeline model. Directed scenarios come first, then a randomized phase.
module tb_cpu_bus_arb;
    import cpu_bus_pkg::*;

    localparam int N = 2;

    logic cpu_clk = 1'b0;
    logic rst;

    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_wr;
    logic [N*CPU_ADDR_W-1:0] req_addr;
    logic [N*CPU_DATA_W-1:0] req_wdata;
    logic [CPU_DATA_W-1:0]   data_out;

    logic                    sel;
    int                      acc;

    logic [N-1:0]            obs_ready;
    logic [N-1:0]            obs_rsp_valid;
    logic [CPU_DATA_W-1:0]   obs_rsp_rdata;
    logic [CPU_ADDR_W-1:0]   obs_addr;
    logic                    obs_cs;
    logic                    obs_wr;
    logic                    obs_rd;
    logic [CPU_DATA_W-1:0]   obs_din;
    logic [N-1:0]            prev_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // timeline model of the most recent accepted transaction
    int                    m_ptr;
    bit                    m_busy;
    int                    t_acc;
    int                    m_owner;
    bit                    m_wr;
    logic [CPU_ADDR_W-1:0] m_addr;
    logic [CPU_DATA_W-1:0] m_wdata;
    logic [CPU_DATA_W-1:0] m_rdata;

    int acc_cyc_log[$];
    int acc_idx_log[$];
    int rsp_cyc_log[$];
    int rsp_data_log[$];
    int cs_count;
    int rsp_count;

    always #5 cpu_clk = ~cpu_clk;

    cpu_bus_arb_if #(.NUM_REQ(N)) bus2 ();
    cpu_bus_arb_if #(.NUM_REQ(N)) bus1 ();

    assign bus2.req_valid    = req_valid;
    assign bus2.req_wr       = req_wr;
    assign bus2.req_addr     = req_addr;
    assign bus2.req_wdata    = req_wdata;
    assign bus2.cpu_data_out = data_out;
    assign bus1.req_valid    = req_valid;
    assign bus1.req_wr       = req_wr;
    assign bus1.req_addr     = req_addr;
    assign bus1.req_wdata    = req_wdata;
    assign bus1.cpu_data_out = data_out;

    cpu_bus_arb #(.NUM_REQ(N), .ACC_CYC(2)) dut2 (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .bus     (bus2)
    );

    cpu_bus_arb #(.NUM_REQ(N), .ACC_CYC(1)) dut1 (
        .cpu_clk (cpu_clk),
        .rst     (rst),
        .bus     (bus1)
    );

    // Route the outputs of the build under test to one set of observation signals.
    always_comb begin
        if (sel) begin
            obs_ready     = bus1.req_ready;
            obs_rsp_valid = bus1.rsp_valid;
            obs_rsp_rdata = bus1.rsp_rdata;
            obs_addr      = bus1.cpu_addr;
            obs_cs        = bus1.cpu_cs;
            obs_wr        = bus1.cpu_wr;
            obs_rd        = bus1.cpu_rd;
            obs_din       = bus1.cpu_data_in;
        end else begin
            obs_ready     = bus2.req_ready;
            obs_rsp_valid = bus2.rsp_valid;
            obs_rsp_rdata = bus2.rsp_rdata;
            obs_addr      = bus2.cpu_addr;
            obs_cs        = bus2.cpu_cs;
            obs_wr        = bus2.cpu_wr;
            obs_rd        = bus2.cpu_rd;
            obs_din       = bus2.cpu_data_in;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, acc %0d)", tag, got, exp, cyc, acc);
        end
    endtask

    function automatic bit getBit(input logic [N-1:0] v, input int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    function automatic int qGet(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic setReq(input int i, input bit v, input bit w,
                          input logic [CPU_ADDR_W-1:0] a, input logic [CPU_DATA_W-1:0] d);
        logic [N-1:0]            bm;
        logic [N*CPU_ADDR_W-1:0] am;
        logic [N*CPU_DATA_W-1:0] dm;
        bm = N'(1) << i;
        am = (N*CPU_ADDR_W)'({CPU_ADDR_W{1'b1}}) << (i*CPU_ADDR_W);
        dm = (N*CPU_DATA_W)'({CPU_DATA_W{1'b1}}) << (i*CPU_DATA_W);
        req_valid = v ? (req_valid | bm) : (req_valid & ~bm);
        req_wr    = w ? (req_wr | bm) : (req_wr & ~bm);
        req_addr  = (req_addr & ~am) | ((N*CPU_ADDR_W)'(a) << (i*CPU_ADDR_W));
        req_wdata = (req_wdata & ~dm) | ((N*CPU_DATA_W)'(d) << (i*CPU_DATA_W));
    endtask

    task automatic clearReqs();
        req_valid = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic clearLogs();
        acc_cyc_log.delete();
        acc_idx_log.delete();
        rsp_cyc_log.delete();
        rsp_data_log.delete();
        cs_count  = 0;
        rsp_count = 0;
    endtask

    task automatic runCycle();
        bit                    idle;
        int                    g;
        int                    j;
        logic [N-1:0]          e_ready;
        logic [50:0]           e_bus;
        logic [50:0]           o_bus;
        logic [N-1:0]          e_rv;
        logic [CPU_DATA_W-1:0] e_rd;
        @(negedge cpu_clk);
        idle = !m_busy || (cyc >= t_acc + acc + 2);
        if (idle) m_busy = 1'b0;
        g = -1;
        if (idle) begin
            for (int k = 0; k < N; k++) begin
                j = (m_ptr + k) % N;
                if (g < 0 && getBit(req_valid, j)) g = j;
            end
        end
        e_ready = (!rst && g >= 0) ? (N'(1) << g) : '0;
        e_bus   = '0;
        e_rv    = '0;
        e_rd    = '0;
        if (m_busy && cyc >= t_acc + 1 && cyc <= t_acc + acc)
            e_bus = {1'b1, m_wr, !m_wr, m_addr, (m_wr ? m_wdata : 16'h0)};
        if (m_busy && cyc == t_acc + acc + 1) begin
            e_rv = N'(1) << m_owner;
            e_rd = m_wr ? 16'h0 : m_rdata;
        end
        o_bus = {obs_cs, obs_wr, obs_rd, obs_addr, obs_din};
        checkOutput("req_ready", 64'(obs_ready), 64'(e_ready));
        checkOutput("bus", 64'(o_bus), 64'(e_bus));
        checkOutput("rsp", 64'({obs_rsp_valid, obs_rsp_rdata}), 64'({e_rv, e_rd}));
        prev_ready = obs_ready;
        for (int k = 0; k < N; k++) begin
            if (getBit(obs_ready, k)) begin
                acc_cyc_log.push_back(cyc);
                acc_idx_log.push_back(k);
            end
        end
        if (obs_cs === 1'b1) cs_count++;
        if (obs_rsp_valid != '0) begin
            rsp_count++;
            rsp_cyc_log.push_back(cyc);
            rsp_data_log.push_back(int'(obs_rsp_rdata));
        end
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
        end else begin
            if (m_busy && cyc == t_acc + acc && !m_wr) m_rdata = data_out;
            if (g >= 0) begin
                m_busy  = 1'b1;
                t_acc   = cyc;
                m_owner = g;
                m_wr    = getBit(req_wr, g);
                m_addr  = CPU_ADDR_W'(req_addr >> (g*CPU_ADDR_W));
                m_wdata = CPU_DATA_W'(req_wdata >> (g*CPU_DATA_W));
                m_ptr   = (g + 1) % N;
            end
        end
        cyc++;
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic resetDut();
        clearReqs();
        rst = 1'b1;
        @(posedge cpu_clk);
        #1;
        m_busy = 1'b0;
        m_ptr  = 0;
        runCycle();
        rst = 1'b0;
    endtask

    task automatic selectDut(input bit s);
        sel = s;
        acc = s ? 1 : 2;
    endtask

    task automatic applyStimulus();
        bit v;
        bit r;
        for (int i = 0; i < N; i++) begin
            v = getBit(req_valid, i);
            r = getBit(prev_ready, i);
            if (!v || r) begin
                if ($urandom_range(0, 99) < 45)
                    setReq(i, 1'b1, 1'($urandom), $urandom, 16'($urandom));
                else
                    setReq(i, 1'b0, 1'b0, '0, '0);
            end else if ($urandom_range(0, 99) < 3) begin
                setReq(i, 1'b0, 1'b0, '0, '0);
            end
        end
        data_out = 16'($urandom);
        rst      = ($urandom_range(0, 199) == 0);
    endtask

    task automatic testWrite();
        int t0;
        resetDut();
        clearLogs();
        data_out = 16'h7777;
        t0 = cyc;
        setReq(0, 1'b1, 1'b1, 32'h0000_1004, 16'hBEEF);
        runCycle();
        setReq(0, 1'b0, 1'b0, '0, '0);
        repeat (4) runCycle();
        checkOutput("wr_accept_cycle", 64'(qGet(acc_cyc_log, 0)), 64'(t0));
        checkOutput("wr_accept_idx", 64'(qGet(acc_idx_log, 0)), 64'(0));
        checkOutput("wr_cs_len", 64'(cs_count), 64'(acc));
        checkOutput("wr_rsp_count", 64'(rsp_count), 64'(1));
        checkOutput("wr_rsp_rdata", 64'(qGet(rsp_data_log, 0)), 64'(0));
    endtask

    task automatic testRead();
        resetDut();
        clearLogs();
        data_out = 16'h1234;
        setReq(1, 1'b1, 1'b0, 32'h0000_0020, 16'h0);
        runCycle();
        setReq(1, 1'b0, 1'b0, '0, '0);
        repeat (4) runCycle();
        checkOutput("rd_accept_idx", 64'(qGet(acc_idx_log, 0)), 64'(1));
        checkOutput("rd_cs_len", 64'(cs_count), 64'(acc));
        checkOutput("rd_latency", 64'(qGet(rsp_cyc_log, 0) - qGet(acc_cyc_log, 0)), 64'(acc + 1));
        checkOutput("rd_rsp_rdata", 64'(qGet(rsp_data_log, 0)), 64'(16'h1234));
    endtask

    task automatic testContention();
        resetDut();
        clearLogs();
        setReq(0, 1'b1, 1'b0, 32'h0000_0100, 16'h0);
        setReq(1, 1'b1, 1'b1, 32'h0000_0200, 16'h5555);
        for (int c = 0; c < 60 && acc_cyc_log.size() < 6; c++) begin
            data_out = 16'($urandom);
            runCycle();
        end
        checkOutput("cont_count", 64'(acc_cyc_log.size()), 64'(6));
        for (int i = 0; i < 6; i++)
            checkOutput("cont_order", 64'(qGet(acc_idx_log, i)), 64'(i % 2));
        for (int i = 1; i < 6; i++)
            checkOutput("cont_period", 64'(qGet(acc_cyc_log, i) - qGet(acc_cyc_log, i-1)), 64'(acc + 2));
        clearReqs();
        repeat (acc + 2) runCycle();
    endtask

    task automatic testBackToBack();
        resetDut();
        clearLogs();
        setReq(0, 1'b1, 1'b1, 32'h0000_0300, 16'hCAFE);
        for (int c = 0; c < 60 && acc_cyc_log.size() < 5; c++) runCycle();
        checkOutput("b2b_count", 64'(acc_cyc_log.size()), 64'(5));
        for (int i = 1; i < 5; i++)
            checkOutput("b2b_period", 64'(qGet(acc_cyc_log, i) - qGet(acc_cyc_log, i-1)), 64'(acc + 2));
        clearReqs();
        repeat (acc + 2) runCycle();
    endtask

    task automatic testResetMid();
        int t0;
        resetDut();
        clearLogs();
        t0 = cyc;
        setReq(0, 1'b1, 1'b1, 32'h0000_0400, 16'hA5A5);
        runCycle();
        setReq(0, 1'b0, 1'b0, '0, '0);
        setReq(1, 1'b1, 1'b0, 32'h0000_0040, 16'h0);
        runCycle();
        rst = 1'b1;
        runCycle();
        rst = 1'b0;
        runCycle();
        checkOutput("rstmid_no_rsp", 64'(rsp_count), 64'(0));
        checkOutput("rstmid_regrant_idx", 64'(qGet(acc_idx_log, 1)), 64'(1));
        checkOutput("rstmid_regrant_cycle", 64'(qGet(acc_cyc_log, 1)), 64'(t0 + 3));
        setReq(1, 1'b0, 1'b0, '0, '0);
        repeat (5) runCycle();
        checkOutput("rstmid_one_rsp", 64'(rsp_count), 64'(1));
    endtask

    initial begin
        rst        = 1'b1;
        data_out   = '0;
        prev_ready = '0;
        m_busy     = 1'b0;
        m_ptr      = 0;
        t_acc      = 0;
        m_owner    = 0;
        m_wr       = 1'b0;
        m_addr     = '0;
        m_wdata    = '0;
        m_rdata    = '0;
        clearReqs();
        clearLogs();
        selectDut(1'b0);
        repeat (2) @(posedge cpu_clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            selectDut(s[0]);
            $display("[TB] running build with ACC_CYC=%0d", acc);
            testWrite();
            testRead();
            testContention();
            testBackToBack();
            if (s == 0) testResetMid();
            resetDut();
            repeat ((s == 0) ? 1500 : 800) begin
                applyStimulus();
                runCycle();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
